// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg -- shared types and helpers for the 8-way round-robin arbiter.
//   state_t : arbiter FSM states (IDLE, GRANT)
//   NUM_REQ : number of requesters (8)
//   IDX_W   : width of a requester index (3)
//   rr_pick : rotating-priority winner search
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Rotating-priority search starting at last+1 and wrapping modulo 8, with
  // last itself considered last. The loop walks offsets from farthest (8,
  // i.e. last) to nearest (1), so the nearest requesting index overwrites
  // any earlier candidate. Result is meaningless when req is all-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    rr_pick = last;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/rr_arb8_ctrl_dec.sv
// onehot_dec3to8 -- binary index to one-hot expansion with enable.
//   en  : input  1  enable; y is all-zero when low
//   idx : input  3  binary index
//   y   : output 8  one-hot of idx when en=1, else 8'h00
module onehot_dec3to8
  import rr_arb_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl -- 8-requester round-robin arbiter with a single grant slot.
//   clk       : input  1  rising-edge clock
//   rst       : input  1  asynchronous active-high reset
//   en        : input  1  global enable; low blocks new grants, revokes current
//   req       : input  8  level-held request lines, bit i = requester i
//   done      : input  1  current grantee releases the resource
//   grant     : output 8  one-hot grant, all-zero when no grant
//   grant_idx : output 3  index of the last granted requester
//   busy      : output 1  high while in GRANT
//   timeout   : output 1  one-cycle pulse on forced release
// Parameter TIMEOUT_CYCLES bounds the grant length only when the macro
// RR_ARB_TIMEOUT_EN is defined; otherwise grants are unbounded and timeout=0.
module rr_arb8_ctrl
  import rr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout
);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] w_winner;
  logic             w_enter;
  logic             w_tmo_hit;

  always_comb w_winner = rr_pick(req, r_last_idx);

  // Any release cause (done, request dropped, enable low, timeout) collapses
  // into the single GRANT->IDLE transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en && (req != '0)) w_next = GRANT;
      GRANT:   if (done || !req[r_grant_idx] || !en || w_tmo_hit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter = (r_state == IDLE) && (w_next == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= 3'd7;
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_grant_idx <= w_winner;
        r_last_idx  <= w_winner;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tcnt;
  logic             r_timeout;

  // r_tcnt counts completed GRANT cycles; the edge ending cycle
  // TIMEOUT_CYCLES forces the release and registers the timeout pulse.
  assign w_tmo_hit = (r_state == GRANT) && (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      if (w_enter) r_tcnt <= '0;
      else if (r_state == GRANT) r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
  assign timeout      = 1'b0;
`endif

  onehot_dec3to8 u_dec (
    .en  (r_state == GRANT),
    .idx (r_grant_idx),
    .y   (grant)
  );

  assign grant_idx = r_grant_idx;
  assign busy      = (r_state == GRANT);

endmodule

// File: doc/rr_arb8_ctrl.md
RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, grant cycles before forced release (used only with RR_ARB_TIMEOUT_EN).
REQ-002 SHALL have one clock, clk; reset rst is asynchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: en  input  1  global enable; low blocks new grants and revokes the current grant.
REQ-006 SHALL have port: req  input  8  request lines, bit i = requester i, level-held until served.
REQ-007 SHALL have port: done  input  1  current grantee releases the resource.
REQ-008 SHALL have port: grant  output  8  one-hot grant, all-zero when no grant.
REQ-009 SHALL have port: grant_idx  output  3  binary index of the last granted requester.
REQ-010 SHALL have port: busy  output  1  high while in GRANT.
REQ-011 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT, with all outputs registered or decoded from registered state.
REQ-013 SHALL transition IDLE->GRANT on the clock edge where en=1 and req!=0, and SHALL drive grant one cycle after req is sampled.
REQ-014 SHALL pick the winner by rotating priority: search last_idx+1, last_idx+2, ... modulo 8, with last_idx checked last.
REQ-015 SHALL load grant_idx and last_idx with the winner on entry to GRANT.
REQ-016 SHALL drive grant = one-hot(grant_idx) when state==GRANT, else 8'h00; busy = (state==GRANT).
REQ-017 SHALL transition GRANT->IDLE on any of: done=1, req[grant_idx]=0, or en=0.
REQ-018 SHALL treat simultaneous release causes as a single release.
REQ-019 SHALL clear grant on the cycle after release, giving a minimum one-cycle gap (IDLE) between consecutive grants.
REQ-020 SHALL ignore done while in IDLE.
REQ-021 SHALL ignore req changes on non-granted lines while in GRANT.
REQ-022 SHALL hold grant_idx at its last value while in IDLE.
REQ-023 SHALL keep a continuously held single request re-granted every second cycle, with the same index.

Reset
REQ-024 SHALL on rst=1, asynchronously, set: state=IDLE, grant=8'h00, grant_idx=3'd0, last_idx=3'd7 (so requester 0 has first priority), busy=0, timeout=0, and the timeout counter to 0.
REQ-025 SHALL, on rst asserted mid-grant, drop grant to zero without waiting for a clock edge.

Configuration
REQ-026 SHALL, with macro RR_ARB_TIMEOUT_EN defined, count cycles spent in GRANT; when the count reaches TIMEOUT_CYCLES, it SHALL force GRANT->IDLE and pulse timeout for one cycle, with the counter cleared on every entry to GRANT.
REQ-027 SHALL, without RR_ARB_TIMEOUT_EN, instantiate no counter, tie timeout to 0, and leave grant length unbounded.

Structure
REQ-028 SHALL place in package rr_arb_pkg: the state enum typedef (IDLE, GRANT), NUM_REQ=8, and IDX_W=3.
REQ-029 SHALL implement the binary-to-one-hot grant expansion as sub-module onehot_dec3to8 (inputs en, idx[2:0]; output y[7:0]), with en driven by the GRANT state.

Verification
REQ-030 SHALL verify: reset, then req=8'h01 with en=1 -> grant=8'h01 and grant_idx=0 one cycle later, busy=1.
REQ-031 SHALL verify: req=8'hFF held, done pulsed each grant -> grant sequence 01,02,04,...,80,01 with one zero cycle between grants.
REQ-032 SHALL verify: grant_idx=3, req=8'h09, then done -> next grant=8'h01 (wrap past 7); with last_idx=0 and req=8'h09 -> next grant=8'h08.
REQ-033 SHALL verify: in GRANT, en dropped to 0 -> grant=00 next cycle, and no new grant while en=0 even with req=8'hFF.
REQ-034 SHALL verify: rst asserted mid-grant (grant=8'h10) -> grant=00 immediately, and after release req=8'h10 is granted first as idx 4 (priority restarts at 0, but 0 is not requesting).
REQ-035 SHALL verify, with RR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, req=8'h04 held and no done -> grant high 4 cycles, timeout pulse 1 cycle, one IDLE cycle, then re-grant 8'h04.
